au_gray_cnt_reg: RTL and testbench

//   Registered Gray-code counter: holds a WIDTH-bit Gray state and advances it by one

---
 rtl/au_gray_cnt_reg_if.sv | 24 ++
 rtl/au_gray_cnt_reg.sv | 108 ++++++++++
 tb/tb_au_gray_cnt_reg.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/au_gray_cnt_reg_if.sv
// Command/status bundle for the registered Gray-code counter.
// The master issues clr/load/en commands; the slave (counter) returns its registered state.
interface au_gray_cnt_reg_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] q_gray;
  logic [WIDTH-1:0] q_bin;
  logic             bin_vld;
  logic             wrap;

  modport master (
    output clr, load, load_val, en,
    input  q_gray, q_bin, bin_vld, wrap
  );

  modport slave (
    input  clr, load, load_val, en,
    output q_gray, q_bin, bin_vld, wrap
  );
endinterface

// File: rtl/au_gray_cnt_reg.sv
// Registered Gray-code counter with sync clear/load, wrap pulse and a one-cycle-lagged
// binary image. The Gray increment goes through parallel-prefix XOR/AND networks chosen by ARCH.
module au_gray_cnt_reg #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input logic              clk,
  input logic              rst,
  au_gray_cnt_reg_if.slave bus
);

  localparam int LOGW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Inclusive prefix from bit 0 upward: ARCH 0 ripple, 1 Sklansky, 2 Kogge-Stone.
  function automatic logic [WIDTH-1:0] prefix_op(input logic [WIDTH-1:0] x,
                                                 input logic use_and);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] prev;
    int j;
    r = x;
    if (ARCH == 0) begin
      for (int i = 1; i < WIDTH; i++) begin
        r[i] = use_and ? (r[i] & r[i-1]) : (r[i] ^ r[i-1]);
      end
    end else begin
      for (int l = 0; l < LOGW; l++) begin
        prev = r;
        for (int i = 0; i < WIDTH; i++) begin
          if (ARCH == 1) begin
            j = (((i >> l) & 1) != 0) ? (((i >> l) << l) - 1) : -1;
          end else begin
            j = i - (1 << l);
          end
          if (j >= 0) begin
            r[i] = use_and ? (prev[i] & prev[j]) : (prev[i] ^ prev[j]);
          end
        end
      end
    end
    return r;
  endfunction

  logic [WIDTH-1:0] q_gray_q, q_gray_d;
  logic [WIDTH-1:0] q_bin_q, q_bin_d;
  logic             bin_vld_q, bin_vld_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] g_rev, bin_rev, bin_cur, carry_pre, carry, bin_nxt, gray_nxt;
  logic [WIDTH-1:0] max_g;

  // gray2bin is a suffix XOR from the MSB, so it runs the prefix network on reversed bits.
  always_comb begin
    g_rev     = '0;
    bin_cur   = '0;
    carry     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      g_rev[i] = q_gray_q[WIDTH-1-i];
    end
    bin_rev = prefix_op(g_rev, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      bin_cur[i] = bin_rev[WIDTH-1-i];
    end
    carry_pre = prefix_op(bin_cur, 1'b1);
    carry[0]  = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = carry_pre[i-1];
    end
    bin_nxt  = bin_cur ^ carry;
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);
  end

  always_comb begin
    max_g            = '0;
    max_g[WIDTH-1]   = 1'b1;
    q_gray_d         = q_gray_q;
    wrap_d           = 1'b0;
    if (bus.clr) begin
      q_gray_d = '0;
    end else if (bus.load) begin
      q_gray_d = bus.load_val;
    end else if (bus.en) begin
      q_gray_d = gray_nxt;
      wrap_d   = (q_gray_q == max_g);
    end
    q_bin_d   = bin_cur;
    bin_vld_d = (q_gray_d == q_gray_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_gray_q  <= '0;
      q_bin_q   <= '0;
      bin_vld_q <= 1'b1;
      wrap_q    <= 1'b0;
    end else begin
      q_gray_q  <= q_gray_d;
      q_bin_q   <= q_bin_d;
      bin_vld_q <= bin_vld_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.q_gray  = q_gray_q;
  assign bus.q_bin   = q_bin_q;
  assign bus.bin_vld = bin_vld_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_au_gray_cnt_reg.sv
// Directed bench for au_gray_cnt_reg: a WIDTH=4 unit for the scenario tests plus a
// WIDTH x ARCH grid of counters sharing one enable stream for the sweep.
module tb_au_gray_cnt_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  au_gray_cnt_reg_if #(.WIDTH(4)) bus();
  au_gray_cnt_reg #(.WIDTH(4), .ARCH(0)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic       sw_clr = 1'b0;
  logic       sw_en  = 1'b0;
  logic [7:0] sw_q    [12];
  logic       sw_wrap [12];

  for (genvar wi = 0; wi < 4; wi++) begin : g_w
    for (genvar ai = 0; ai < 3; ai++) begin : g_a
      localparam int W = (wi == 0) ? 1 : (wi == 1) ? 2 : (wi == 2) ? 3 : 8;
      au_gray_cnt_reg_if #(.WIDTH(W)) sif();
      assign sif.clr      = sw_clr;
      assign sif.load     = 1'b0;
      assign sif.load_val = '0;
      assign sif.en       = sw_en;
      au_gray_cnt_reg #(.WIDTH(W), .ARCH(ai)) u_dut (.clk(clk), .rst(rst), .bus(sif));
      assign sw_q[wi*3+ai]    = 8'(sif.q_gray);
      assign sw_wrap[wi*3+ai] = sif.wrap;
    end
  end

  logic [3:0] t1_seq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  function automatic int sw_width(input int k);
    case (k / 3)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 4'h0; bus.en = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.q_gray !== 4'h0) begin
      miscompares++; $display("[TB] FAIL reset_q_gray got %h want 0", bus.q_gray);
    end
    vectors++;
    if (bus.q_bin !== 4'h0) begin
      miscompares++; $display("[TB] FAIL reset_q_bin got %h want 0", bus.q_bin);
    end
    vectors++;
    if (bus.bin_vld !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_bin_vld got %b want 1", bus.bin_vld);
    end
    vectors++;
    if (bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_wrap got %b want 0", bus.wrap);
    end
    bus.en = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic test_count();
    bus.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (bus.q_gray !== t1_seq[i+1]) begin
        miscompares++; $display("[TB] FAIL count_q_gray step %0d got %h want %h", i, bus.q_gray, t1_seq[i+1]);
      end
      vectors++;
      if (bus.wrap !== (i == 15)) begin
        miscompares++; $display("[TB] FAIL count_wrap step %0d got %b want %b", i, bus.wrap, (i == 15));
      end
      vectors++;
      if ($countones(bus.q_gray ^ t1_seq[i]) != 1) begin
        miscompares++; $display("[TB] FAIL count_onebit step %0d got %0d flips want 1", i, $countones(bus.q_gray ^ t1_seq[i]));
      end
      vectors++;
      if (bus.q_bin !== 4'(i)) begin
        miscompares++; $display("[TB] FAIL count_q_bin step %0d got %h want %h", i, bus.q_bin, 4'(i));
      end
      vectors++;
      if (bus.bin_vld !== 1'b0) begin
        miscompares++; $display("[TB] FAIL count_bin_vld step %0d got %b want 0", i, bus.bin_vld);
      end
    end
    bus.en = 1'b0;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h0) begin
      miscompares++; $display("[TB] FAIL idle_q_gray got %h want 0", bus.q_gray);
    end
    vectors++;
    if (bus.q_bin !== 4'h0) begin
      miscompares++; $display("[TB] FAIL idle_q_bin got %h want 0", bus.q_bin);
    end
    vectors++;
    if (bus.bin_vld !== 1'b1) begin
      miscompares++; $display("[TB] FAIL idle_bin_vld got %b want 1", bus.bin_vld);
    end
    vectors++;
    if (bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_wrap got %b want 0", bus.wrap);
    end
  endtask

  task automatic test_load_wrap();
    bus.load = 1'b1; bus.en = 1'b1; bus.load_val = 4'h8;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h8) begin
      miscompares++; $display("[TB] FAIL load_q_gray got %h want 8", bus.q_gray);
    end
    vectors++;
    if (bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_wrap got %b want 0", bus.wrap);
    end
    bus.load = 1'b0;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h0) begin
      miscompares++; $display("[TB] FAIL max_inc_q_gray got %h want 0", bus.q_gray);
    end
    vectors++;
    if (bus.wrap !== 1'b1) begin
      miscompares++; $display("[TB] FAIL max_inc_wrap got %b want 1", bus.wrap);
    end
    bus.en = 1'b0;
    tick();
    vectors++;
    if (bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wrap_pulse_end got %b want 0", bus.wrap);
    end
  endtask

  task automatic test_priority();
    bus.load = 1'b1; bus.load_val = 4'h6;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h6) begin
      miscompares++; $display("[TB] FAIL preload_q_gray got %h want 6", bus.q_gray);
    end
    bus.clr = 1'b1; bus.load = 1'b1; bus.en = 1'b1; bus.load_val = 4'h5;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h0) begin
      miscompares++; $display("[TB] FAIL clr_prio_q_gray got %h want 0", bus.q_gray);
    end
    vectors++;
    if (bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL clr_prio_wrap got %b want 0", bus.wrap);
    end
    vectors++;
    if (bus.bin_vld !== 1'b0) begin
      miscompares++; $display("[TB] FAIL clr_change_bin_vld got %b want 0", bus.bin_vld);
    end
    tick();
    vectors++;
    if (bus.bin_vld !== 1'b1) begin
      miscompares++; $display("[TB] FAIL clr_at_zero_bin_vld got %b want 1", bus.bin_vld);
    end
    bus.clr = 1'b0;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h5) begin
      miscompares++; $display("[TB] FAIL load_beats_en_q_gray got %h want 5", bus.q_gray);
    end
    bus.en = 1'b0;
    tick();
    vectors++;
    if (bus.bin_vld !== 1'b1) begin
      miscompares++; $display("[TB] FAIL same_load_bin_vld got %b want 1", bus.bin_vld);
    end
    vectors++;
    if (bus.q_bin !== 4'h6) begin
      miscompares++; $display("[TB] FAIL q_bin_of_5 got %h want 6", bus.q_bin);
    end
    bus.load = 1'b0;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h5) begin
      miscompares++; $display("[TB] FAIL hold_q_gray got %h want 5", bus.q_gray);
    end
  endtask

  task automatic test_async_reset();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0; bus.en = 1'b1;
    repeat (9) tick();
    vectors++;
    if (bus.q_gray !== 4'hD) begin
      miscompares++; $display("[TB] FAIL pre_rst_q_gray got %h want d", bus.q_gray);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus.q_gray !== 4'h0) begin
      miscompares++; $display("[TB] FAIL async_rst_q_gray got %h want 0", bus.q_gray);
    end
    vectors++;
    if (bus.q_bin !== 4'h0) begin
      miscompares++; $display("[TB] FAIL async_rst_q_bin got %h want 0", bus.q_bin);
    end
    vectors++;
    if (bus.bin_vld !== 1'b1) begin
      miscompares++; $display("[TB] FAIL async_rst_bin_vld got %b want 1", bus.bin_vld);
    end
    vectors++;
    if (bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL async_rst_wrap got %b want 0", bus.wrap);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.q_gray !== 4'h1) begin
      miscompares++; $display("[TB] FAIL post_rst_q_gray got %h want 1", bus.q_gray);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_sweep();
    int   bmod [12];
    int   wraps_seen [12];
    int   enabled;
    int   cycles;
    int   w;
    int   mask;
    logic e;
    logic exp_wrap;
    logic [7:0] exp_g;
    enabled = 0;
    cycles  = 0;
    sw_clr  = 1'b1;
    tick();
    sw_clr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bmod[k]       = 0;
      wraps_seen[k] = 0;
      vectors++;
      if (sw_q[k] !== 8'h00) begin
        miscompares++; $display("[TB] FAIL sweep_clr inst %0d got %h want 0", k, sw_q[k]);
      end
    end
    while (enabled < 259 && cycles < 2000) begin
      e     = ($urandom_range(0, 3) != 0);
      sw_en = e;
      tick();
      cycles++;
      if (e) enabled++;
      for (int k = 0; k < 12; k++) begin
        w        = sw_width(k);
        mask     = (1 << w) - 1;
        exp_wrap = 1'b0;
        if (e) begin
          exp_wrap = (bmod[k] == mask);
          bmod[k]  = (bmod[k] + 1) & mask;
        end
        exp_g = 8'((bmod[k] ^ (bmod[k] >> 1)) & mask);
        vectors++;
        if (sw_q[k] !== exp_g) begin
          miscompares++; $display("[TB] FAIL sweep_q inst %0d cyc %0d got %h want %h", k, cycles, sw_q[k], exp_g);
        end
        vectors++;
        if (sw_wrap[k] !== exp_wrap) begin
          miscompares++; $display("[TB] FAIL sweep_wrap inst %0d cyc %0d got %b want %b", k, cycles, sw_wrap[k], exp_wrap);
        end
        if (sw_wrap[k] === 1'b1) wraps_seen[k]++;
      end
    end
    sw_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (wraps_seen[k] != (enabled >> sw_width(k))) begin
        miscompares++; $display("[TB] FAIL sweep_wrap_count inst %0d got %0d want %0d", k, wraps_seen[k], enabled >> sw_width(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_wrap();
    test_priority();
    test_async_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
